// File: rtl/ncc_scan_controller.sv
// NCC correlator scan sequencer: shifts the descriptor in from the PCI byte
// stream, walks one window row out of the window BRAM through the PE chain,
// and keeps the best (maximum) correlation score with its column position.
module ncc_scan_controller #(
    parameter int DESC_PIXELS = 256,
    parameter int WIN_W       = 80,
    parameter int PE_COLS     = 16,
    parameter int ACC_W       = 32,
    parameter int ADDR_W      = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [7:0]               pci_in,
    input  logic                     pci_valid,
    output logic                     pci_ready,
    output logic                     desc_load,
    output logic                     desc_shift,
    output logic                     win_rd_en,
    output logic [ADDR_W-1:0]        win_addr,
    output logic                     pe_win_load,
    output logic                     pe_acc_load,
    input  logic signed [ACC_W-1:0]  score_in,
    output logic                     busy,
    output logic                     done,
    output logic signed [ACC_W-1:0]  best_score,
    output logic [$clog2(WIN_W)-1:0] best_pos
);

    localparam int DCW = $clog2(DESC_PIXELS + 1);
    localparam int LCW = $clog2(WIN_W + 1);
    localparam int PW  = $clog2(WIN_W);

    localparam logic [DCW-1:0]          DESC_LAST   = DCW'(DESC_PIXELS - 1);
    localparam logic [ADDR_W-1:0]       RD_LAST     = ADDR_W'(WIN_W - 1);
    localparam logic [LCW-1:0]          LD_LAST     = LCW'(WIN_W);
    localparam logic [LCW-1:0]          LD_FIRST_SC = LCW'(PE_COLS);
    localparam logic signed [ACC_W-1:0] SCORE_MIN   = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_DESC,
        S_SCAN,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e                   state_q, state_d;
    logic [DCW-1:0]           desc_cnt_q, desc_cnt_d;
    logic [ADDR_W-1:0]        rd_cnt_q, rd_cnt_d;
    logic [LCW-1:0]           ld_cnt_q, ld_cnt_d;
    logic                     pe_load_q;
    logic                     sample_q;
    logic signed [ACC_W-1:0]  best_score_q, best_score_d;
    logic [PW-1:0]            best_pos_q, best_pos_d;
    logic                     start_match;
    logic                     score_win;

    // Descriptor bytes travel straight from the PCI bus into the descriptor
    // shift register; the controller only supplies the load/shift strobes.
    logic unused_pci;
    assign unused_pci = ^pci_in;

    // BRAM read data arrives one cycle after the strobe, so PE loads trail it.
    assign pe_win_load = pe_load_q;
    assign pe_acc_load = pe_load_q;
    assign best_score  = best_score_q;
    assign best_pos    = best_pos_q;

    // Next-state logic and per-state strobes.
    always_comb begin
        state_d     = state_q;
        desc_cnt_d  = desc_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        start_match = 1'b0;
        pci_ready   = 1'b0;
        desc_load   = 1'b0;
        desc_shift  = 1'b0;
        win_rd_en   = 1'b0;
        win_addr    = '0;
        busy        = 1'b1;
        done        = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    start_match = 1'b1;
                    desc_cnt_d  = '0;
                    rd_cnt_d    = '0;
                    state_d     = S_LOAD_DESC;
                end
            end
            S_LOAD_DESC: begin
                pci_ready = 1'b1;
                if (pci_valid) begin
                    desc_load  = (desc_cnt_q == '0);
                    desc_shift = (desc_cnt_q != '0);
                    desc_cnt_d = desc_cnt_q + 1'b1;
                    if (desc_cnt_q == DESC_LAST) begin
                        state_d = S_SCAN;
                    end
                end
            end
            S_SCAN: begin
                win_rd_en = 1'b1;
                win_addr  = rd_cnt_q;
                rd_cnt_d  = rd_cnt_q + 1'b1;
                if (rd_cnt_q == RD_LAST) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Leave once the score belonging to the final load is sampled.
                if (sample_q && (ld_cnt_q == LD_LAST)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Load counting and best-score tracking; ties keep the earlier position.
    always_comb begin
        ld_cnt_d     = ld_cnt_q;
        best_score_d = best_score_q;
        best_pos_d   = best_pos_q;
        // sample_q marks the cycle after load n, when ld_cnt_q already equals n.
        score_win    = sample_q && (ld_cnt_q >= LD_FIRST_SC) && (score_in > best_score_q);
        if (start_match) begin
            ld_cnt_d     = '0;
            best_score_d = SCORE_MIN;
            best_pos_d   = '0;
        end else begin
            if (pe_load_q) begin
                ld_cnt_d = ld_cnt_q + 1'b1;
            end
            if (score_win) begin
                best_score_d = score_in;
                best_pos_d   = PW'(ld_cnt_q - LD_FIRST_SC);
            end
        end
    end

    // State, counters and result registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            desc_cnt_q   <= '0;
            rd_cnt_q     <= '0;
            ld_cnt_q     <= '0;
            pe_load_q    <= 1'b0;
            sample_q     <= 1'b0;
            best_score_q <= '0;
            best_pos_q   <= '0;
        end else begin
            state_q      <= state_d;
            desc_cnt_q   <= desc_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            ld_cnt_q     <= ld_cnt_d;
            pe_load_q    <= win_rd_en;
            sample_q     <= pe_load_q;
            best_score_q <= best_score_d;
            best_pos_q   <= best_pos_d;
        end
    end

endmodule

// File: tb/tb_ncc_scan_controller.sv
// Scoreboard bench for ncc_scan_controller: each match pushes its expected
// best score/position; a negedge monitor pops at every done pulse and also
// checks strobe sequencing cycle by cycle.
`timescale 1ns/1ps
module tb_ncc_scan_controller;

    localparam int DESC_PIXELS = 256;
    localparam int WIN_W       = 80;
    localparam int PE_COLS     = 16;
    localparam int ACC_W       = 32;
    localparam int ADDR_W      = 10;
    localparam int PW          = $clog2(WIN_W);
    localparam longint SCORE_MIN_L = -64'sd2147483648;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    start = 1'b0;
    logic [7:0]              pci_in = '0;
    logic                    pci_valid = 1'b0;
    logic                    pci_ready;
    logic                    desc_load;
    logic                    desc_shift;
    logic                    win_rd_en;
    logic [ADDR_W-1:0]       win_addr;
    logic                    pe_win_load;
    logic                    pe_acc_load;
    logic signed [ACC_W-1:0] score_in = '0;
    logic                    busy;
    logic                    done;
    logic signed [ACC_W-1:0] best_score;
    logic [PW-1:0]           best_pos;

    ncc_scan_controller #(
        .DESC_PIXELS (DESC_PIXELS),
        .WIN_W       (WIN_W),
        .PE_COLS     (PE_COLS),
        .ACC_W       (ACC_W),
        .ADDR_W      (ADDR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .pci_in      (pci_in),
        .pci_valid   (pci_valid),
        .pci_ready   (pci_ready),
        .desc_load   (desc_load),
        .desc_shift  (desc_shift),
        .win_rd_en   (win_rd_en),
        .win_addr    (win_addr),
        .pe_win_load (pe_win_load),
        .pe_acc_load (pe_acc_load),
        .score_in    (score_in),
        .busy        (busy),
        .done        (done),
        .best_score  (best_score),
        .best_pos    (best_pos)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    typedef struct {
        longint score;
        longint pos;
    } exp_t;
    exp_t exp_q[$];

    // Score model for the last PE, indexed by window position.
    int mode = 0;
    function automatic logic signed [31:0] score_fn(input int m, input int p);
        case (m)
            0:       return (p == 40) ? 32'sd5000 : 32'(10 * p);
            1:       return (p == 3 || p == 9) ? 32'sd12 : -32'sd7;
            2:       return 32'(-100 - p);
            default: return 32'(p);
        endcase
    endfunction

    // Last-PE stand-in: score for load n appears in the cycle after that load.
    // Outside valid positions it drives the largest value to expose bad sampling.
    int ld_n = 0;
    bit load_prev = 1'b0;
    always @(negedge clk) begin
        if (load_prev && ld_n >= PE_COLS) score_in = score_fn(mode, ld_n - PE_COLS);
        else                              score_in = 32'sh7FFF_FFFF;
        if (!busy)            ld_n = 0;
        else if (pe_acc_load) ld_n++;
        load_prev = pe_acc_load;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: strobe sequencing every cycle, scoreboard pop on done.
    bit mon_en = 1'b0;
    bit prev_rd = 1'b0;
    bit prev_done = 1'b0;
    int acc_cnt, acc_cyc, rd_cnt, first_rd_cyc, last_rd_cyc, ld_cnt_m, n_load, n_shift;
    always @(negedge clk) begin
        if (mon_en) begin
            bit acc;
            exp_t e;
            acc = pci_valid && pci_ready;
            if (!busy) begin
                acc_cnt = 0; rd_cnt = 0; ld_cnt_m = 0; n_load = 0; n_shift = 0;
                acc_cyc = -1000; first_rd_cyc = -1000; last_rd_cyc = -1000;
            end
            chk("pe_win_load_lag", longint'(pe_win_load), longint'(prev_rd));
            chk("pe_acc_load_lag", longint'(pe_acc_load), longint'(prev_rd));
            chk("desc_load_strobe", longint'(desc_load), longint'(acc && acc_cnt == 0));
            chk("desc_shift_strobe", longint'(desc_shift), longint'(acc && acc_cnt != 0));
            if (desc_load)  n_load++;
            if (desc_shift) n_shift++;
            if (acc) begin
                acc_cnt++;
                if (acc_cnt == DESC_PIXELS) acc_cyc = cyc;
            end
            if (win_rd_en) begin
                chk("win_addr", longint'(win_addr), longint'(rd_cnt));
                chk("pci_ready_in_scan", longint'(pci_ready), 0);
                if (rd_cnt == 0) first_rd_cyc = cyc;
                last_rd_cyc = cyc;
                rd_cnt++;
            end
            if (pe_win_load) ld_cnt_m++;
            if (done) begin
                chk("done_width", longint'(prev_done), 0);
                chk("busy_at_done", longint'(busy), 1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", longint'(exp_q.size()), 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("best_score", longint'(best_score), e.score);
                    chk("best_pos", longint'(best_pos), e.pos);
                    chk("done_latency", longint'(cyc - acc_cyc), WIN_W + 3);
                    chk("scan_start", longint'(first_rd_cyc), longint'(acc_cyc + 1));
                    chk("read_span", longint'(last_rd_cyc - first_rd_cyc), WIN_W - 1);
                    chk("read_count", longint'(rd_cnt), WIN_W);
                    chk("pe_load_count", longint'(ld_cnt_m), WIN_W);
                    chk("desc_load_count", longint'(n_load), 1);
                    chk("desc_shift_count", longint'(n_shift), DESC_PIXELS - 1);
                end
            end
            prev_rd   = win_rd_en;
            prev_done = done;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_pci_ready"},   longint'(pci_ready), 0);
        chk({tag, "_desc_load"},   longint'(desc_load), 0);
        chk({tag, "_desc_shift"},  longint'(desc_shift), 0);
        chk({tag, "_win_rd_en"},   longint'(win_rd_en), 0);
        chk({tag, "_win_addr"},    longint'(win_addr), 0);
        chk({tag, "_pe_win_load"}, longint'(pe_win_load), 0);
        chk({tag, "_pe_acc_load"}, longint'(pe_acc_load), 0);
        chk({tag, "_busy"},        longint'(busy), 0);
        chk({tag, "_done"},        longint'(done), 0);
        chk({tag, "_best_score"},  longint'(best_score), 0);
        chk({tag, "_best_pos"},    longint'(best_pos), 0);
    endtask

    task automatic run_match(input int m, input bit toggle, input bit poke,
                             input longint es, input longint ep);
        int b;
        int k;
        int t;
        bit acc;
        mode = m;
        exp_q.push_back('{score: es, pos: ep});
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("best_cleared", longint'(best_score), SCORE_MIN_L);
        b = 0;
        k = 0;
        while (b < DESC_PIXELS && k < 4 * DESC_PIXELS) begin
            pci_valid = (toggle && (k % 2 != 0)) ? 1'b0 : 1'b1;
            pci_in    = b[7:0];
            acc       = pci_valid && pci_ready;
            tick();
            k++;
            if (acc) b++;
        end
        chk("feed_count", longint'(b), DESC_PIXELS);
        pci_valid = poke;
        if (poke) begin
            repeat (5) tick();
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        t = 0;
        while (busy && t < 400) begin
            tick();
            t++;
        end
        chk("match_ends", longint'(busy), 0);
        pci_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_zero("reset");
        rst = 1'b1;
        tick();
        mon_en = 1'b1;
        tick();

        // Abort a descriptor load part way through.
        start = 1'b1;
        tick();
        start = 1'b0;
        pci_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            pci_in = 8'(i);
            tick();
        end
        pci_valid = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check_idle_zero("midrst");
        repeat (5) tick();

        // Peak at p=40, descriptor delivered with bubbles every other cycle.
        run_match(0, 1'b1, 1'b0, 5000, 40);
        repeat (3) tick();
        chk("hold_best_score", longint'(best_score), 5000);
        chk("hold_best_pos", longint'(best_pos), 40);

        // Ties among negatives; start and pci_valid poked while scanning.
        run_match(1, 1'b0, 1'b1, 12, 3);
        // All negative and falling: first position wins.
        run_match(2, 1'b0, 1'b0, -100, 0);
        // Rising: best sits on the last covered position.
        run_match(3, 1'b1, 1'b0, WIN_W - PE_COLS, WIN_W - PE_COLS);

        repeat (5) tick();
        chk("scoreboard_empty", longint'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ncc_scan_controller.md
Name: ncc_scan_controller

Overview:
- Sequencer for the NCC correlator. Loads the descriptor byte stream into the descriptor shift register, then walks one window row from the window BRAM through the 16-PE systolic array.
- Pulses the PE window and accumulator load enables and tracks the best (maximum) correlation score with its column position.
- Sits between the PCI byte interface, the window row BRAM (port A read) and the PE chain.

Parameters:
- DESC_PIXELS, 256: descriptor bytes to shift in per match.
- WIN_W, 80: pixels per window row (BRAM depth used).
- PE_COLS, 16: PEs in the chain (pipeline fill depth).
- ACC_W, 32: width of the signed score from the last PE.
- ADDR_W, 10: window BRAM address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low (asserted when 0).
- start  in  1  begin a match; honoured only in IDLE.
- pci_in  in  8  descriptor byte.
- pci_valid  in  1  pci_in holds a byte.
- pci_ready  out  1  controller accepts pci_in this cycle.
- desc_load  out  1  load the first byte into the descriptor register.
- desc_shift  out  1  shift the descriptor register by 8 and insert the byte.
- win_rd_en  out  1  window BRAM read strobe.
- win_addr  out  ADDR_W  window BRAM read address.
- pe_win_load  out  1  loadWinReg to all PEs.
- pe_acc_load  out  1  loadAccSumReg to all PEs.
- score_in  in  ACC_W  signed accOut of the last PE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the result is valid.
- best_score  out  ACC_W  maximum score of the last completed match.
- best_pos  out  $clog2(WIN_W)  column offset of best_score.

Behaviour:
- Reset (rst==0 at a clock edge):
  - state goes to IDLE; all counters are cleared.
  - Every output is 0: pci_ready, desc_load, desc_shift, win_rd_en, win_addr, pe_win_load, pe_acc_load, busy, done, best_score, best_pos.
  - A reset mid-operation aborts immediately. No done pulse is issued. Partial results are discarded.
- States: IDLE, LOAD_DESC, SCAN, DRAIN, DONE.
- IDLE:
  - pci_ready=0.
  - start=1 clears desc_cnt, rd_cnt, ld_cnt and best_score (to the most negative ACC_W value), then moves to LOAD_DESC.
  - best_score and best_pos hold their previous values until that start.
- LOAD_DESC:
  - pci_ready=1. A byte is accepted when pci_valid && pci_ready.
  - The first accepted byte asserts desc_load; every later accepted byte asserts desc_shift, in the same cycle as acceptance.
  - desc_cnt increments per accepted byte. When the DESC_PIXELS-th byte is accepted, the next state is SCAN.
  - Bubbles (pci_valid=0) stall with no strobes.
  - start is ignored in every state except IDLE.
- SCAN:
  - pci_ready=0.
  - Each cycle: win_rd_en=1, win_addr=rd_cnt, rd_cnt++.
  - After address WIN_W-1 is issued, the next state is DRAIN.
  - No stalls. Exactly WIN_W reads on consecutive cycles.
- PE timing:
  - BRAM read latency is 1 cycle, so pe_win_load=pe_acc_load=1 in the cycle after each win_rd_en. ld_cnt counts these loads (1-based n).
  - score_in is valid in the cycle after load n.
  - For n >= PE_COLS the controller samples score_in as position p = n - PE_COLS.
  - The positions covered are 0 .. WIN_W-PE_COLS (65 positions at default parameters).
- Best tracking:
  - Signed compare. Update only if score_in > best_score (strictly greater).
  - On a tie the lower position is kept.
- DRAIN: no reads. Waits until the final load (n=WIN_W) has issued and its score has been sampled, then moves to DONE.
- DONE:
  - done=1 for one cycle.
  - best_score and best_pos are final and stable from this cycle.
  - Next state is IDLE.
- busy=1 in LOAD_DESC, SCAN, DRAIN and DONE.
- Latency: from the cycle after the last descriptor byte is accepted to done is WIN_W + 3 cycles (83 at default parameters).

Test Plan:
- Reset mid-operation: reset, then start; feed 100 bytes; pull rst low for 1 cycle -> all outputs 0, state IDLE, no done pulse; a later start runs cleanly.
- Descriptor load: 256 bytes 0x00..0xFF with pci_valid toggled every other cycle -> exactly 1 desc_load (first byte) + 255 desc_shift pulses, each coincident with acceptance; SCAN starts the cycle after byte 255 is accepted.
- Scan sequencing: after the descriptor -> win_addr 0..79 on 80 consecutive cycles; pe_win_load/pe_acc_load are each high for 80 cycles, lagging win_rd_en by one cycle; done is asserted 83 cycles after the last byte is accepted.
- Max tracking: score model returns 10*p, except p=40 returns 5000 -> best_score=5000, best_pos=40.
- Ties and negatives: all scores -7, except p=3 and p=9 which return 12 -> best_score=12, best_pos=3.
- Busy behaviour: start pulsed during SCAN -> ignored; pci_valid held high during SCAN -> pci_ready=0 and no desc strobes.
